// File: rtl/icache_assoc_if.sv
// -----------------------------------------------------------------------------
// icache_assoc_if
//   Bus bundle for the set-associative instruction cache. It groups three sides:
//     - fetch : flush_icache, addr (in), hit, inst (out)
//     - MMU   : mmu_valid, mmu_vaddr (out), mmu_hit, mmu_paddr (in)
//     - AXI   : AR channel (arvalid/arready/araddr/arid/arlen/arsize/arburst)
//               and R channel (rvalid/rready/rdata/rresp/rlast)
//   Modports:
//     master : the cache. It masters the MMU request and the AXI read.
//     slave  : the environment, which is fetch, the MMU and the AXI slave.
// -----------------------------------------------------------------------------
interface icache_assoc_if;
    logic        flush_icache;
    logic [31:0] addr;
    logic        hit;
    logic [31:0] inst;

    logic        mmu_valid;
    logic [31:0] mmu_vaddr;
    logic        mmu_hit;
    logic [31:0] mmu_paddr;

    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;

    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;

    modport master (
        input  flush_icache, addr, mmu_hit, mmu_paddr, arready,
               rvalid, rdata, rresp, rlast,
        output hit, inst, mmu_valid, mmu_vaddr, arvalid, araddr, arid,
               arlen, arsize, arburst, rready
    );

    modport slave (
        output flush_icache, addr, mmu_hit, mmu_paddr, arready,
               rvalid, rdata, rresp, rlast,
        input  hit, inst, mmu_valid, mmu_vaddr, arvalid, araddr, arid,
               arlen, arsize, arburst, rready
    );
endinterface

// File: rtl/icache_assoc.sv
// -----------------------------------------------------------------------------
// icache_assoc
//   N-way set-associative instruction cache that sits between the IFU fetch
//   stage, the MMU and an AXI read port.
//   - A hit is combinational. inst is taken from the way whose tag matches.
//   - On a miss the cache translates the address through the MMU. It then
//     issues one WRAP burst that starts at the missing word, so the critical
//     word arrives first.
//   - The victim is the lowest invalid way in the set. If the set is full, the
//     victim is that set's round-robin pointer.
//   - If any beat returns an error response, the line stays invalid and the
//     miss re-issues.
//   Ports:
//     clock, reset : clock and synchronous active-high reset
//     bus          : icache_assoc_if.master (fetch, MMU and AXI signals)
// -----------------------------------------------------------------------------
module icache_assoc #(
    parameter int OFFSET_W = 4,   // log2 line bytes, >= 2
    parameter int INDEX_W  = 2,   // log2 set count
    parameter int WAYS_W   = 1    // log2 way count, 0 = direct-mapped
) (
    input  logic           clock,
    input  logic           reset,
    icache_assoc_if.master bus
);
    localparam int WAYS     = 1 << WAYS_W;
    localparam int SETS     = 1 << INDEX_W;
    localparam int TAG_W    = 32 - OFFSET_W - INDEX_W;
    localparam int BLOCK_SZ = (1 << OFFSET_W) >> 2;
    localparam int BEAT_W   = (OFFSET_W > 2) ? OFFSET_W - 2 : 1;
    localparam int WAY_IW   = (WAYS_W > 0) ? WAYS_W : 1;

    typedef enum logic [1:0] {S_IDLE, S_MMU, S_REQ, S_RESP} state_e;

    // Address split. The fetch stage holds addr stable while hit is 0, so the
    // refill takes its index and tag directly from addr.
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
    logic [29:0]        word_addr;
    logic [BEAT_W-1:0]  off;

    assign tag       = bus.addr[31 -: TAG_W];
    assign index     = bus.addr[OFFSET_W +: INDEX_W];
    assign word_addr = bus.addr[31:2];
    assign off       = BEAT_W'(word_addr & 30'(BLOCK_SZ - 1));

    // Storage
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAY_IW-1:0] rr_q    [SETS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [31:0]       data_q  [SETS][WAYS][BLOCK_SZ];

    // Refill state
    state_e            state_q,  state_d;
    logic [WAY_IW-1:0] victim_q, victim_d;
    logic [31:0]       paddr_q,  paddr_d;
    logic [BEAT_W-1:0] beat_q,   beat_d;
    logic              err_q,    err_d;

    logic              hit;
    logic [31:0]       inst;
    logic [WAY_IW-1:0] victim_pick;
    logic [WAY_IW-1:0] rr_inc;
    logic              mmu_valid, arvalid, rready;
    logic              beat_fire, fill_ok;

    // Lookup. Refill never allocates a duplicate, so at most one way matches.
    // NOTE: every signal written in an always_comb gets a default first. A
    // path that leaves a signal unassigned would otherwise infer a latch.
    always_comb begin
        hit  = 1'b0;
        inst = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[index][w] && (tag_q[index][w] == tag)) begin
                hit  = 1'b1;
                inst = data_q[index][w][off];
            end
        end
    end

    // Victim choice: the lowest invalid way, otherwise the round-robin pointer.
    // The loop runs downward so that the lowest-numbered invalid way wins.
    always_comb begin
        victim_pick = rr_q[index];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[index][w]) victim_pick = WAY_IW'(w);
        end
    end

    // The mask keeps the pointer at 0 when the cache is direct-mapped.
    assign rr_inc = (rr_q[index] + 1'b1) & WAY_IW'(WAYS - 1);

    // Next-state logic and handshake outputs
    always_comb begin
        state_d   = state_q;
        victim_d  = victim_q;
        paddr_d   = paddr_q;
        beat_d    = beat_q;
        err_d     = err_q;
        mmu_valid = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        beat_fire = 1'b0;
        fill_ok   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!hit) begin
                    state_d  = S_MMU;
                    victim_d = victim_pick;
                end
            end
            S_MMU: begin
                mmu_valid = 1'b1;
                if (bus.mmu_hit) begin
                    paddr_d = {bus.mmu_paddr[31:2], 2'b00};
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                arvalid = 1'b1;
                if (bus.arready) begin
                    state_d = S_RESP;
                    beat_d  = off;
                    err_d   = 1'b0;
                end
            end
            S_RESP: begin
                rready = 1'b1;
                if (bus.rvalid) begin
                    beat_fire = 1'b1;
                    beat_d    = (beat_q + 1'b1) & BEAT_W'(BLOCK_SZ - 1);
                    if (bus.rresp != 2'b00) err_d = 1'b1;
                    // A flush during the burst does not abort it. The burst is
                    // always drained up to rlast.
                    if (bus.rlast) begin
                        fill_ok = !(err_q || (bus.rresp != 2'b00));
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state and valid bits
    // NOTE: sequential blocks use non-blocking assignments only, so every
    // register samples the values from before the clock edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            victim_q <= '0;
            paddr_q  <= '0;
            beat_q   <= '0;
            err_q    <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            paddr_q  <= paddr_d;
            beat_q   <= beat_d;
            err_q    <= err_d;
            if (bus.flush_icache) begin
                for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
            end
            // This assignment comes after the flush, so when both happen in
            // one cycle the line that just completed stays valid.
            if (fill_ok) begin
                valid_q[index][victim_q] <= 1'b1;
                // The pointer advances only when the set was already full
                // before this fill.
                if (&valid_q[index]) rr_q[index] <= rr_inc;
            end
        end
    end

    // Tag and data arrays
    // NOTE: the tag and data arrays are not reset. The valid bits guard every
    // read of them, and leaving these arrays out of reset keeps them mappable
    // to RAM.
    always_ff @(posedge clock) begin
        if (beat_fire) data_q[index][victim_q][beat_q] <= bus.rdata;
        if (fill_ok)   tag_q[index][victim_q]          <= tag;
    end

    // Output wiring
    assign bus.hit       = hit;
    assign bus.inst      = inst;
    assign bus.mmu_valid = mmu_valid;
    assign bus.mmu_vaddr = {bus.addr[31:2], 2'b00};
    assign bus.arvalid   = arvalid;
    assign bus.araddr    = paddr_q;
    assign bus.arid      = 4'd0;
    assign bus.arlen     = 8'(BLOCK_SZ - 1);
    assign bus.arsize    = 3'b010;
    assign bus.arburst   = (BLOCK_SZ == 1) ? 2'b00 : 2'b10;
    assign bus.rready    = rready;

    // The byte-offset bits of both addresses are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.addr[1:0], bus.mmu_paddr[1:0]};
endmodule

// File: tb/tb_icache_assoc.sv
// -----------------------------------------------------------------------------
// tb_icache_assoc
//   Directed testbench for icache_assoc with the default parameters: 16-byte
//   lines (4 words), 4 sets and 2 ways. The bench acts as the fetch stage, the
//   MMU and the AXI slave. Inputs change on the falling edge, and outputs are
//   sampled 1 time unit later.
//   Word k of a line is filled with the value base + k, so the expected inst
//   value follows directly from the address.
// -----------------------------------------------------------------------------
module tb_icache_assoc;
    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    icache_assoc_if bus ();

    icache_assoc dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Probe one address without letting a clock edge pass.
    task automatic probe(input string tag, input logic [31:0] a,
                         input logic exp_hit, input logic [31:0] exp_inst);
        bus.addr = a;
        settle;
        check({tag, "_hit"}, 32'(bus.hit), 32'(exp_hit));
        if (exp_hit) check({tag, "_inst"}, bus.inst, exp_inst);
    endtask

    task automatic miss_start(input logic [31:0] a);
        bus.addr = a;
        settle;
        check("miss_hit", 32'(bus.hit), 32'd0);
        check("idle_mmu_valid", 32'(bus.mmu_valid), 32'd0);
        tick;
    endtask

    task automatic mmu_phase(input logic [31:0] a, input logic [31:0] pa, input int dly);
        for (int i = 0; i < dly; i++) begin
            settle;
            check("mmu_wait_valid", 32'(bus.mmu_valid), 32'd1);
            check("mmu_wait_arvalid", 32'(bus.arvalid), 32'd0);
            tick;
        end
        bus.mmu_hit   = 1'b1;
        bus.mmu_paddr = pa;
        settle;
        check("mmu_valid", 32'(bus.mmu_valid), 32'd1);
        check("mmu_vaddr", bus.mmu_vaddr, {a[31:2], 2'b00});
        tick;
        bus.mmu_hit   = 1'b0;
        bus.mmu_paddr = '0;
    endtask

    task automatic ar_phase(input logic [31:0] exp_araddr, input int dly);
        for (int i = 0; i < dly; i++) begin
            settle;
            check("ar_wait_arvalid", 32'(bus.arvalid), 32'd1);
            check("ar_wait_araddr", bus.araddr, exp_araddr);
            tick;
        end
        bus.arready = 1'b1;
        settle;
        check("arvalid", 32'(bus.arvalid), 32'd1);
        check("araddr", bus.araddr, exp_araddr);
        check("arlen", 32'(bus.arlen), 32'd3);
        check("arburst", 32'(bus.arburst), 32'd2);
        check("arsize", 32'(bus.arsize), 32'd2);
        check("arid", 32'(bus.arid), 32'd0);
        tick;
        bus.arready = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic [1:0] resp, input logic last,
                        input logic flush, input int gap);
        for (int i = 0; i < gap; i++) begin
            settle;
            check("gap_rready", 32'(bus.rready), 32'd1);
            check("gap_no_extra_ar", 32'(bus.arvalid), 32'd0);
            tick;
        end
        bus.rvalid       = 1'b1;
        bus.rdata        = d;
        bus.rresp        = resp;
        bus.rlast        = last;
        bus.flush_icache = flush;
        settle;
        check("beat_rready", 32'(bus.rready), 32'd1);
        tick;
        bus.rvalid       = 1'b0;
        bus.rdata        = '0;
        bus.rresp        = 2'b00;
        bus.rlast        = 1'b0;
        bus.flush_icache = 1'b0;
    endtask

    // Full miss and refill. The bench returns beats in wrap order, starting at
    // the missing word. err_beat < 0 means every beat returns OKAY.
    task automatic fill(input logic [31:0] a, input logic [31:0] pa, input logic [31:0] base,
                        input int err_beat, input int mmu_dly, input int ar_dly,
                        input int gap, input logic flush_last);
        int w;
        miss_start(a);
        mmu_phase(a, pa, mmu_dly);
        ar_phase({pa[31:2], 2'b00}, ar_dly);
        for (int k = 0; k < 4; k++) begin
            w = (int'(a[3:2]) + k) % 4;
            beat(base + 32'(w), (k == err_beat) ? 2'b10 : 2'b00, k == 3,
                 flush_last && (k == 3), gap);
        end
    endtask

    initial begin
        reset            = 1'b1;
        bus.flush_icache = 1'b0;
        bus.addr         = 32'h8000_0008;
        bus.mmu_hit      = 1'b0;
        bus.mmu_paddr    = '0;
        bus.arready      = 1'b0;
        bus.rvalid       = 1'b0;
        bus.rdata        = '0;
        bus.rresp        = 2'b00;
        bus.rlast        = 1'b0;
        tick;
        tick;
        reset = 1'b0;
        settle;

        // Reset state
        check("rst_hit", 32'(bus.hit), 32'd0);
        check("rst_mmu_valid", 32'(bus.mmu_valid), 32'd0);
        check("rst_arvalid", 32'(bus.arvalid), 32'd0);
        check("rst_rready", 32'(bus.rready), 32'd0);

        // Cold miss on word 2: the burst wraps as A2, A3, A0, A1.
        fill(32'h8000_0008, 32'h8000_0008, 32'hA0, -1, 0, 0, 0, 1'b0);
        probe("cold_w2", 32'h8000_0008, 1'b1, 32'hA2);
        probe("cold_w0", 32'h8000_0000, 1'b1, 32'hA0);
        probe("cold_w3", 32'h8000_000C, 1'b1, 32'hA3);

        // Associativity. 0x40 goes into the free way 1. 0x80 then evicts way 0
        // via rr = 0, because the set was not full before the 0x40 fill.
        fill(32'h8000_0040, 32'h8000_0040, 32'hB0, -1, 0, 0, 0, 1'b0);
        probe("assoc_a", 32'h8000_0000, 1'b1, 32'hA0);
        probe("assoc_b", 32'h8000_0044, 1'b1, 32'hB1);
        fill(32'h8000_0080, 32'h8000_0080, 32'hC0, -1, 0, 0, 0, 1'b0);
        probe("evict_a", 32'h8000_0000, 1'b0, 32'h0);
        probe("keep_b", 32'h8000_0040, 1'b1, 32'hB0);
        probe("new_c", 32'h8000_0088, 1'b1, 32'hC2);

        // An error on beat 1 leaves the line invalid. The same AR re-issues.
        fill(32'h8000_0010, 32'h8000_0010, 32'hD0, 1, 0, 0, 0, 1'b0);
        probe("err_nohit", 32'h8000_0010, 1'b0, 32'h0);
        fill(32'h8000_0010, 32'h8000_0010, 32'hD0, -1, 0, 0, 0, 1'b0);
        probe("retry_hit", 32'h8000_0014, 1'b1, 32'hD1);

        // A flush on its own clears every line.
        bus.addr         = 32'h8000_0088;
        bus.flush_icache = 1'b1;
        tick;
        bus.flush_icache = 1'b0;
        probe("flush_c", 32'h8000_0088, 1'b0, 32'h0);
        probe("flush_d", 32'h8000_0010, 1'b0, 32'h0);

        // A flush that coincides with the rlast of the 0x40 fill keeps only
        // that fill's line.
        fill(32'h8000_0000, 32'h8000_0000, 32'hE0, -1, 0, 0, 0, 1'b0);
        probe("pre_flush_a", 32'h8000_0004, 1'b1, 32'hE1);
        fill(32'h8000_0040, 32'h8000_0040, 32'hF0, -1, 0, 0, 0, 1'b1);
        probe("flush_keep_b", 32'h8000_0044, 1'b1, 32'hF1);
        probe("flush_drop_a", 32'h8000_0000, 1'b0, 32'h0);

        // Backpressure: the MMU answers after 3 cycles and arready comes after
        // 2 cycles. There is a 1-cycle gap before each beat. The address is
        // translated, and the byte offset of mmu_paddr is dropped.
        fill(32'h8000_0024, 32'h1234_5626, 32'h50, -1, 3, 2, 1, 1'b0);
        probe("bp_w1", 32'h8000_0024, 1'b1, 32'h51);
        probe("bp_w0", 32'h8000_0020, 1'b1, 32'h50);
        probe("bp_w3", 32'h8000_002C, 1'b1, 32'h53);

        // Reset asserted in the middle of a refill
        miss_start(32'h8000_0030);
        mmu_phase(32'h8000_0030, 32'h8000_0030, 0);
        ar_phase(32'h8000_0030, 0);
        beat(32'h70, 2'b00, 1'b0, 1'b0, 0);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        settle;
        check("midrst_rready", 32'(bus.rready), 32'd0);
        check("midrst_mmu_valid", 32'(bus.mmu_valid), 32'd0);
        probe("midrst_bp", 32'h8000_0024, 1'b0, 32'h0);
        probe("midrst_b", 32'h8000_0044, 1'b0, 32'h0);
        probe("midrst_d", 32'h8000_0010, 1'b0, 32'h0);
        probe("midrst_e", 32'h8000_0030, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
